// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced carry-lookahead add/subtract datapath.
package alu_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter needs at least one bit even for a single-chunk build.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second lookahead level.
module cla_16 (
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic        sub_flag,
    output logic [15:0] sum,
    output logic        carry_out
);

    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, cg;

    // Carries into bits 0..3 of a 4-bit group, given its carry-in.
    function automatic logic [3:0] carries4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
        logic [3:0] cc;
        cc[0] = ci;
        cc[1] = gi[0] | (pi[0] & ci);
        cc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        cc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
        return cc;
    endfunction

    function automatic logic group_g(input logic [3:0] gi, input logic [3:0] pi);
        return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    endfunction

    assign g = src1 & src2;
    assign p = src1 ^ src2;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign gg[k]       = group_g(g[4*k +: 4], p[4*k +: 4]);
        assign gp[k]       = &p[4*k +: 4];
        assign c[4*k +: 4] = carries4(g[4*k +: 4], p[4*k +: 4], cg[k]);
    end

    assign cg        = carries4(gg, gp, sub_flag);
    assign carry_out = group_g(gg, gp) | ((&gp) & sub_flag);
    assign sum       = p ^ c;

endmodule

// File: rtl/cla_seq_addsub.sv
// WIDTH-bit add/subtract built from one 16-bit CLA slice reused LSB chunk first,
// with the inter-chunk carry held in a flop and valid/ready on both sides.
module cla_seq_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNKS = WIDTH / SLICE_W;
    localparam int IDX_W  = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 2 * SLICE_W) begin : g_bad_width
        $error("cla_seq_addsub: WIDTH must be a multiple of 16 and at least 32");
    end

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_a = op_a[int'(idx) * SLICE_W +: SLICE_W];
    assign slice_b = op_b[int'(idx) * SLICE_W +: SLICE_W];

    // op_b is already inverted for subtraction, so the slice only ever adds.
    cla_16 u_slice (
        .src1      (slice_a),
        .src2      (slice_b),
        .sub_flag  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= src1;
                        op_b     <= sub ? ~src2 : src2;
                        carry_q  <= sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[int'(idx) * SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        carry_out <= slice_cout;
                        // Same-sign operands producing an opposite-sign result.
                        overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                     (slice_sum[SLICE_W-1] != op_a[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
